// File: rtl/fp_mantissa_mult_seq_pkg.sv
// Purpose : shared constants and FSM encoding for the FP32 significand multiply path.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package fp_mult_pkg;

  // Significand, exponent and raw product widths for single precision.
  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int PROD_W = 2 * MANT_W;

  // FP32 field positions, shared with the unpack and rounding stages.
  localparam int FP32_W        = 32;
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_FRAC_MSB = 22;
  localparam int FP32_FRAC_LSB = 0;
  localparam int FP32_EXP_BIAS = 127;

  // Raw-product bits the rounding stage looks at when bit 47 is clear.
  localparam int RND_NORM_BIT = PROD_W - 2;
  localparam int RND_MANT_MSB = PROD_W - 3;
  localparam int RND_MANT_LSB = MANT_W - 1;

  // Iterative multiplier controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

endpackage : fp_mult_pkg

// File: rtl/fp_mantissa_mult_seq_if.sv
// Purpose : request/result bundle between the unpack stage and the sequential multiplier.
// Latency : n/a (wires only).
// Backpressure: none; the requester watches busy and waits for the done pulse.
interface fp_mantissa_mult_seq_if #(
  parameter int MANT_W = fp_mult_pkg::MANT_W
);

  localparam int PROD_W = 2 * MANT_W;

  logic              start;
  logic [MANT_W-1:0] mant_a;
  logic [MANT_W-1:0] mant_b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  // Requester side: issues operands, receives the product.
  modport master (
    output start,
    output mant_a,
    output mant_b,
    input  busy,
    input  done,
    input  product
  );

  // Multiplier side.
  modport slave (
    input  start,
    input  mant_a,
    input  mant_b,
    output busy,
    output done,
    output product
  );

endinterface : fp_mantissa_mult_seq_if

// File: rtl/fp_mantissa_mult_seq.sv
// Purpose : radix-2 shift-add multiply of two significands into a full-width raw product.
// Latency : 26 cycles counting the accept cycle and the done cycle (1 accept + MANT_W RUN + 1 DONE).
// Backpressure: none; start is accepted only in IDLE, ignored (not queued) while busy.
module fp_mantissa_mult_seq #(
  parameter int MANT_W = fp_mult_pkg::MANT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_mantissa_mult_seq_if.slave bus
);

  import fp_mult_pkg::*;

  // Product width is tied to the significand width; never set on its own.
  localparam int PROD_W = 2 * MANT_W;
  localparam int CNT_W  = $clog2(MANT_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MANT_W - 1);

  mult_state_t       state_q,   state_d;
  logic [PROD_W-1:0] mcand_q,   mcand_d;
  logic [MANT_W-1:0] mplier_q,  mplier_d;
  logic [PROD_W-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  // Next-state, datapath step and registered-output values for the controller.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d  = {{MANT_W{1'b0}}, bus.mant_a};
          mplier_d = bus.mant_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
          busy_d   = 1'b1;
        end
      end

      ST_RUN: begin
        busy_d = 1'b1;
        // One multiplier bit per cycle; zero operands still take every step
        // so the latency seen downstream is fixed.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Capture the final sum (including this cycle's add) as we enter DONE.
          state_d   = ST_DONE;
          product_d = acc_d;
          done_d    = 1'b1;
        end
      end

      ST_DONE: begin
        // A start seen here belongs to the busy window and is dropped.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule : fp_mantissa_mult_seq
